// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default
// width, count-width helper and the half-subtractor cell.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Result of one half-subtractor cell: difference and borrow.
    typedef struct packed {
        logic d;
        logic b;
    } hs_t;

    // Bits needed for a counter that runs 0..w-1.
    function automatic int count_width(input int w);
        return $clog2(w);
    endfunction

    // Half-subtractor cell: x - y.
    function automatic hs_t half_sub(input logic x, input logic y);
        hs_t r;
        r.d = x ^ y;
        r.b = ~x & y;
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One full-subtractor stage (x - y - bin) built from two half-subtractor
// cells; their borrows are ORed to form the stage borrow.
module full_subtractor_bit
    import serial_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    hs_t hs_xy;
    hs_t hs_bin;

    // First cell subtracts the operands, second cell subtracts the borrow-in.
    always_comb begin
        hs_xy  = half_sub(x, y);
        hs_bin = half_sub(hs_xy.d, bin);
        d      = hs_bin.d;
        bout   = hs_xy.b | hs_bin.b;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B, one bit per clock, LSB first,
// valid/ready handshakes on both sides.
// Optional macro SERIAL_SUB_SATURATE_EN: clamp diff to 0 when the final
// borrow is set (borrow_out still reports 1).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int            CW   = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 difference bits produced so far; the final bit is
    // combined straight into the result on the last shift edge.
    logic [WIDTH-2:0] d_sr;
    logic             borrow;
    logic [CW-1:0]    count;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] result;

    full_subtractor_bit u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign d_next = {bit_d, d_sr};

`ifdef SERIAL_SUB_SATURATE_EN
    assign result = bit_bout ? '0 : d_next;
`else
    assign result = d_next;
`endif

    // FSM, datapath shift registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            borrow     <= 1'b0;
            count      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow   <= 1'b0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    d_sr   <= d_next[WIDTH-1:1];
                    borrow <= bit_bout;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        diff       <= result;
                        borrow_out <= bit_bout;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // diff/borrow_out are frozen here until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

`ifdef SERIAL_SUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation with out_ready high and check latency and result.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        logic early;
        early     = 1'b0;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        repeat (7) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
        end
        chk({tag, "_early"}, {31'd0, early}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
        @(negedge clk);
        chk({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic subtraction with latency check
        run_op("t5a23", 8'h5A, 8'h23, 8'h37, 1'b0);
        // Underflow: wrap or clamp
        run_op("t1020", 8'h10, 8'h20, SAT ? 8'h00 : 8'hF0, 1'b1);
        // Extreme corner
        run_op("t00ff", 8'h00, 8'hFF, SAT ? 8'h00 : 8'h01, 1'b1);

        // Back-to-back with in_valid held high: period of 10 cycles
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_acc1", {31'd0, in_ready}, 32'd0);
        a = 8'h00; b = 8'h01;
        repeat (8) @(negedge clk);
        chk("b2b_v1", {31'd0, out_valid}, 32'd1);
        chk("b2b_d1", {23'd0, borrow_out, diff}, 32'h000);
        @(negedge clk);
        chk("b2b_idle", {30'd0, out_valid, in_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_acc2", {30'd0, in_ready, busy}, 32'd1);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_v2", {31'd0, out_valid}, 32'd1);
        chk("b2b_d2", {23'd0, borrow_out, diff}, SAT ? 32'h100 : 32'h1FF);
        @(negedge clk);

        // Back-pressure: hold result for 5 cycles, ignore extra in_valid
        a = 8'h10; b = 8'h20; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 8'h77; b = 8'h11;
        repeat (8) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {22'd0, out_valid, in_ready, borrow_out, diff},
                {22'd0, 1'b1, 1'b0, 1'b1, SAT ? 8'h00 : 8'hF0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
        @(negedge clk);
        chk("bp_no_accept", {31'd0, busy}, 32'd0);

        // Asynchronous reset after 3 bits of SHIFT
        a = 8'h9C; b = 8'h41; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_now", {20'd0, in_ready, out_valid, busy, borrow_out, diff},
            {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("ar_no_valid", {31'd0, seen}, 32'd0);
        chk("ar_ready", {31'd0, in_ready}, 32'd1);
        run_op("t0503", 8'h05, 8'h03, 8'h02, 1'b0);

        // Operands changed during SHIFT must not affect result
        a = 8'hC3; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'h00; b = 8'hFF;
        repeat (8) @(negedge clk);
        chk("chg_valid", {31'd0, out_valid}, 32'd1);
        chk("chg_diff", {23'd0, borrow_out, diff}, 32'h087);
        @(negedge clk);

        // Equal operands
        run_op("t4242", 8'h42, 8'h42, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
